// File: rtl/id_issue_buffer.sv
// id_issue_buffer: multi-port in-order FIFO between parallel decoders and the issue stage
module id_issue_buffer #(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           flush_unissued_instr_i,
  input  logic [NR_PORTS-1:0]            fetch_entry_valid_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] fetch_entry_i,
  input  logic [NR_PORTS-1:0]            fetch_is_ctrl_flow_i,
  output logic [NR_PORTS-1:0]            fetch_entry_ready_o,
  output logic [NR_PORTS-1:0]            xif_issue_valid_o,
  input  logic [NR_PORTS-1:0]            xif_issue_ready_i,
  output logic [DATA_WIDTH-1:0]          issue_entry_o,
  output logic                           issue_entry_valid_o,
  output logic                           is_ctrl_flow_o,
  input  logic                           issue_instr_ack_i,
  output logic [$clog2(DEPTH):0]         occupancy_o
);
  localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_ctrl, r_valid;
  logic [PW-1:0]         r_rptr, r_wptr;
  logic [CW-1:0]         r_count, w_k;
  logic [CW:0]           w_free;
  logic                  w_pop, w_gate;
  logic [NR_PORTS-1:0]   w_xv, w_acc;
  logic [PW-1:0]         w_idx [NR_PORTS];
  assign w_pop  = issue_instr_ack_i & (r_count != '0);
  assign w_gate = ~flush_i & ~flush_unissued_instr_i;
  assign w_free = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
  // a refused port, or a pushed control-flow entry, stops every younger port
  always_comb begin
    logic pf;
    pf    = 1'b1;
    w_xv  = '0;
    w_acc = '0;
    w_k   = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      w_xv[p]  = w_gate & fetch_entry_valid_i[p] & pf & ((CW+1)'(p) < w_free);
      w_acc[p] = w_xv[p] & xif_issue_ready_i[p];
      pf       = w_acc[p] & ~fetch_is_ctrl_flow_i[p];
      w_k      = w_k + CW'(w_acc[p]);
      w_idx[p] = PW'((int'(r_wptr) + p) % DEPTH);
    end
  end
  assign xif_issue_valid_o   = w_xv;
  assign fetch_entry_ready_o = w_acc;
  assign issue_entry_o       = r_valid[r_rptr] ? r_data[r_rptr] : '0;
  assign is_ctrl_flow_o      = r_valid[r_rptr] & r_ctrl[r_rptr];
  assign issue_entry_valid_o = r_count != '0;
  assign occupancy_o         = r_count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ctrl  <= '0;
      for (int d = 0; d < DEPTH; d++) r_data[d] <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= PW'((int'(r_rptr) + 1) % DEPTH);
      end
      for (int p = 0; p < NR_PORTS; p++) begin
        if (w_acc[p]) begin
          r_data[w_idx[p]]  <= fetch_entry_i[p*DATA_WIDTH +: DATA_WIDTH];
          r_ctrl[w_idx[p]]  <= fetch_is_ctrl_flow_i[p];
          r_valid[w_idx[p]] <= 1'b1;
        end
      end
      r_wptr  <= PW'((int'(r_wptr) + int'(w_k)) % DEPTH);
      r_count <= r_count + w_k - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_id_issue_buffer.sv
// tb_id_issue_buffer: randomized scoreboard bench against a queue-based reference model
module tb_id_issue_buffer;
  localparam int NP = 2, D = 4, W = 64, CW = $clog2(D) + 1;
  typedef struct packed {logic [W-1:0] d; logic c;} ent_t;
  logic clk_i = 0, rst_ni = 0, flush_i = 0, flush_unissued_instr_i = 0, issue_instr_ack_i = 0;
  logic [NP-1:0] fetch_entry_valid_i = '0, fetch_is_ctrl_flow_i = '0, xif_issue_ready_i = '0;
  logic [NP*W-1:0] fetch_entry_i = '0;
  logic [NP-1:0] fetch_entry_ready_o, xif_issue_valid_o;
  logic [W-1:0] issue_entry_o;
  logic issue_entry_valid_o, is_ctrl_flow_o;
  logic [CW-1:0] occupancy_o;
  ent_t q[$];
  int checks = 0, errors = 0;

  id_issue_buffer #(.NR_PORTS(NP), .DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .flush_unissued_instr_i(flush_unissued_instr_i),
    .fetch_entry_valid_i(fetch_entry_valid_i), .fetch_entry_i(fetch_entry_i),
    .fetch_is_ctrl_flow_i(fetch_is_ctrl_flow_i), .fetch_entry_ready_o(fetch_entry_ready_o),
    .xif_issue_valid_o(xif_issue_valid_o), .xif_issue_ready_i(xif_issue_ready_i),
    .issue_entry_o(issue_entry_o), .issue_entry_valid_o(issue_entry_valid_o),
    .is_ctrl_flow_o(is_ctrl_flow_o), .issue_instr_ack_i(issue_instr_ack_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // monitor: every real pop must deliver the oldest entry the model holds
  always @(negedge clk_i) begin
    if (rst_ni && issue_entry_valid_o && issue_instr_ack_i && !flush_i) begin
      if (q.size() == 0) chk("pop_with_empty_model", W'(1), W'(0));
      else begin
        ent_t e;
        e = q.pop_front();
        chk("head_data", issue_entry_o, e.d);
        chk("head_ctrl", W'(is_ctrl_flow_o), W'(e.c));
      end
    end
  end

  task automatic cyc(input logic [NP-1:0] v, r, c, input logic ack, fl, fu);
    logic [NP-1:0] ev, ea;
    int fr, k;
    bit stop;
    @(posedge clk_i); #1;
    fetch_entry_valid_i = v; xif_issue_ready_i = r; fetch_is_ctrl_flow_i = c;
    issue_instr_ack_i = ack; flush_i = fl; flush_unissued_instr_i = fu;
    for (int p = 0; p < NP; p++) fetch_entry_i[p*W +: W] = {$urandom, $urandom};
    #1;
    fr = D - q.size() + ((ack && q.size() != 0) ? 1 : 0);
    ev = '0; ea = '0; stop = fl || fu;
    for (int p = 0; p < NP && !stop; p++) begin
      if (!v[p] || p >= fr) stop = 1;
      else begin
        ev[p] = 1'b1;
        if (!r[p]) stop = 1;
        else begin
          ea[p] = 1'b1;
          if (c[p]) stop = 1;
        end
      end
    end
    chk("occupancy", W'(occupancy_o), W'(q.size()));
    chk("head_valid", W'(issue_entry_valid_o), W'(q.size() != 0));
    chk("xif_valid", W'(xif_issue_valid_o), W'(ev));
    chk("fetch_ready", W'(fetch_entry_ready_o), W'(ea));
    k = 0;
    if (fl) q.delete();
    else for (int p = 0; p < NP; p++) if (ea[p]) q.push_back('{fetch_entry_i[p*W +: W], c[p]});
  endtask

  initial begin
    #2;
    chk("rst_occupancy", W'(occupancy_o), W'(0));
    chk("rst_valid", W'(issue_entry_valid_o), W'(0));
    chk("rst_ctrl", W'(is_ctrl_flow_o), W'(0));
    chk("rst_data", issue_entry_o, W'(0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b01, 2'b11, 2'b00, 1, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1, 0, 0);
    cyc(2'b11, 2'b11, 2'b01, 0, 0, 0);
    cyc(2'b01, 2'b11, 2'b00, 1, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1, 0, 0);
    cyc(2'b11, 2'b10, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b11, 2'b00, 1, 1, 0);
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b11, 2'b00, 1, 0, 1);
    repeat (10) cyc(2'b01, 2'b01, 2'b00, 1, 0, 0);
    repeat (3000) begin
      logic [NP-1:0] rv, rr, rc;
      rv = NP'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
      rc = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      cyc(rv, rr, rc, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
          $urandom_range(0, 9) == 0);
    end
    repeat (D + 2) cyc(2'b00, 2'b00, 2'b00, 1, 0, 0);
    chk("drained", W'(q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
